// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_pkg
//  Description : Shared types and helpers for the JK command sequencer:
//                per-bit JK operation encoding, sequencer FSM state type and
//                the single-bit JK next-state function used by the flop model.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    // Per-flop operation, encoded as {j,k}
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TGL  = 2'b11
    } jk_op_t;

    // Sequencer FSM state
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } jk_state_t;

    // Next value of one JK flop given its current value and the sampled op
    function automatic logic jk_apply(input logic q, input jk_op_t op);
        logic v;
        case (op)
            HOLD:    v = q;
            CLR:     v = 1'b0;
            SET:     v = 1'b1;
            TGL:     v = ~q;
            default: v = q;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cmd_sequencer_if
//  Description : Command handshake bundle feeding the JK command sequencer.
//                master : command producer (drives valid/op/rpt)
//                slave  : sequencer (drives ready)
//  Ports       : cmd_valid  - command offered
//                cmd_ready  - sequencer FIFO can accept
//                cmd_op     - per-bit op, bits [2i+1:2i] = {j,k} of flop i
//                cmd_rpt    - op applied for cmd_rpt+1 cycles
//  Revision    : 1.0 - initial release
// ============================================================================
interface jk_cmd_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2*WIDTH-1:0]   cmd_op;
    logic [CNT_W-1:0]     cmd_rpt;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rpt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rpt,
        output cmd_ready
    );

endinterface
`default_nettype wire

// File: rtl/jk_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cmd_fifo
//  Description : Synchronous first-word-fall-through FIFO holding sequencer
//                commands. Head entry is visible on rdata whenever not empty.
//                Push is ignored when full, pop is ignored when empty; both
//                decisions use the registered occupancy only.
//  Ports       : clk, rst          - clock, async active-high reset
//                push, wdata       - write request and data
//                pop, rdata        - read request and head data
//                full, empty       - occupancy flags
//                count             - occupancy, log2(DEPTH)+1 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];

    assign w_push = push & ~full;
    assign w_pop  = pop  & ~empty;

    // Storage carries no reset; only pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cmd_sequencer
//  Description : Command sequencer upstream of a JK flip-flop bank. Buffers
//                per-bit JK op words in a FIFO and replays each one on the
//                registered j/k lines for cmd_rpt+1 cycles, back-to-back
//                entries abutting with no idle cycle.
//                Optional checker (macro JK_SEQ_CHECK_EN): models the flop
//                bank state on q_exp and sets sticky mismatch when q_fb
//                diverges. Without the macro q_exp and mismatch are 0 and
//                q_fb is ignored.
//  Ports       : clk, rst   - clock, async active-high reset
//                cmd        - command handshake (slave modport)
//                j, k       - registered JK drives
//                q_fb       - q fed back from the flop bank
//                busy       - driving or FIFO non-empty
//                q_exp      - modelled flop state
//                mismatch   - sticky compare failure
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_cmd_sequencer_if.slave    cmd,
    output logic [WIDTH-1:0]     j,
    output logic [WIDTH-1:0]     k,
    input  logic [WIDTH-1:0]     q_fb,
    output logic                 busy,
    output logic [WIDTH-1:0]     q_exp,
    output logic                 mismatch
);

    localparam int c_DATA_W = 2*WIDTH + CNT_W;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [c_DATA_W-1:0]      w_wdata;
    logic [c_DATA_W-1:0]      w_rdata;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_pop;

    assign w_wdata       = {cmd.cmd_op, cmd.cmd_rpt};
    assign cmd.cmd_ready = ~w_full;

    jk_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (c_DATA_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (cmd.cmd_valid),
        .wdata  (w_wdata),
        .pop    (w_pop),
        .rdata  (w_rdata),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    // Split the head entry into per-flop j/k vectors and repeat count
    logic [2*WIDTH-1:0] w_head_op;
    logic [CNT_W-1:0]   w_head_rpt;
    logic [WIDTH-1:0]   w_head_j;
    logic [WIDTH-1:0]   w_head_k;

    assign w_head_op  = w_rdata[c_DATA_W-1:CNT_W];
    assign w_head_rpt = w_rdata[CNT_W-1:0];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unpack
        assign w_head_j[gi] = w_head_op[2*gi+1];
        assign w_head_k[gi] = w_head_op[2*gi];
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    jk_state_t          r_state;
    jk_state_t          w_state_nxt;
    logic [WIDTH-1:0]   r_j;
    logic [WIDTH-1:0]   r_k;
    logic [WIDTH-1:0]   w_j_nxt;
    logic [WIDTH-1:0]   w_k_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_j     <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt holds the number of cycles still to come after the current one,
    // so a freshly loaded op lasts cmd_rpt+1 cycles and cnt never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_j_nxt = '0;
                w_k_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_j_nxt     = w_head_j;
                    w_k_nxt     = w_head_k;
                    w_cnt_nxt   = w_head_rpt;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!w_empty) begin
                    // Chain straight into the next entry: no gap cycle
                    w_pop     = 1'b1;
                    w_j_nxt   = w_head_j;
                    w_k_nxt   = w_head_k;
                    w_cnt_nxt = w_head_rpt;
                end else begin
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_j_nxt     = '0;
                w_k_nxt     = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign j    = r_j;
    assign k    = r_k;
    assign busy = (r_state == ST_DRIVE) | (w_count != '0);

    // ------------------------------------------------------------------
    // Optional flop-state model and compare
    // ------------------------------------------------------------------
`ifdef JK_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_q_exp;
    logic [WIDTH-1:0] w_q_exp_nxt;
    logic             r_mismatch;

    // The model sees the same registered j/k the flop bank samples
    for (genvar gm = 0; gm < WIDTH; gm++) begin : g_model
        assign w_q_exp_nxt[gm] = jk_apply(r_q_exp[gm], jk_op_t'({r_j[gm], r_k[gm]}));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_exp    <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_q_exp    <= w_q_exp_nxt;
            r_mismatch <= r_mismatch | (q_fb != r_q_exp);
        end
    end

    assign q_exp    = r_q_exp;
    assign mismatch = r_mismatch;
`else
    logic w_unused_q_fb;

    assign w_unused_q_fb = ^q_fb;
    assign q_exp         = '0;
    assign mismatch      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_cmd_sequencer
//  Description : Self-checking bench for jk_cmd_sequencer. A behavioural
//                flop bank drives q_fb. The reference model keeps pending
//                commands in a queue and expands each started command into
//                a per-cycle schedule of op words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_cmd_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] j, k, q_fb, q_exp;
    logic             busy, mismatch;
    logic [WIDTH-1:0] flop;
    logic [WIDTH-1:0] inj = '0;

    jk_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    jk_cmd_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if),
        .j        (j),
        .k        (k),
        .q_fb     (q_fb),
        .busy     (busy),
        .q_exp    (q_exp),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    // Behavioural JK flop bank, characteristic equation q+ = j~q | ~kq
    always @(posedge clk or posedge rst) begin
        if (rst) flop <= '0;
        else     flop <= (j & ~flop) | (~k & flop);
    end
    assign q_fb = flop ^ inj;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] op;
        logic [3:0] rpt;
    } cmd_t;

    cmd_t       mq[$];      // accepted, not yet started
    logic [7:0] sched[$];   // one op word per remaining drive cycle
    logic [3:0] m_q;
    logic       m_mis;

    int n_vec = 0;
    int n_mis = 0;

    function automatic logic [3:0] op_j(input logic [7:0] op);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = op[2*i+1];
        return r;
    endfunction

    function automatic logic [3:0] op_k(input logic [7:0] op);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = op[2*i];
        return r;
    endfunction

    function automatic logic [7:0] cur_op();
        return (sched.size() > 0) ? sched[0] : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sched.delete();
        m_q   = '0;
        m_mis = 1'b0;
    endtask

    // Advance the model across one rising edge using pre-edge values
    task automatic model_edge();
        logic [3:0] cj, ck;
        cmd_t       c;
        logic       do_push;
        cj      = op_j(cur_op());
        ck      = op_k(cur_op());
        do_push = cmd_if.cmd_valid && (mq.size() < DEPTH);
        m_mis   = m_mis | (q_fb != m_q);
        m_q     = (cj & ~m_q) | (~ck & m_q);
        if (sched.size() > 0) void'(sched.pop_front());
        if (sched.size() == 0 && mq.size() > 0) begin
            c = mq.pop_front();
            for (int r = 0; r <= int'(c.rpt); r++) sched.push_back(c.op);
        end
        if (do_push) mq.push_back({cmd_if.cmd_op, cmd_if.cmd_rpt});
    endtask

    task automatic check_outputs();
        logic [3:0] eq;
        logic       em;
`ifdef JK_SEQ_CHECK_EN
        eq = m_q;
        em = m_mis;
`else
        eq = '0;
        em = 1'b0;
`endif
        check("j",         j,                op_j(cur_op()));
        check("k",         k,                op_k(cur_op()));
        check("cmd_ready", cmd_if.cmd_ready, (mq.size() < DEPTH));
        check("busy",      busy,             (sched.size() > 0 || mq.size() > 0));
        check("q_exp",     q_exp,            eq);
        check("mismatch",  mismatch,         em);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Asserts reset asynchronously, checks reset values, releases after an edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_j",     j,                4'h0);
        check("rst_k",     k,                4'h0);
        check("rst_ready", cmd_if.cmd_ready, 1'b1);
        check("rst_busy",  busy,             1'b0);
        check("rst_q_exp", q_exp,            4'h0);
        check("rst_mis",   mismatch,         1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && (sched.size() > 0 || mq.size() > 0); t++) tick();
        check("drain_busy", busy, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: single command into an idle sequencer
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] op;
        logic [3:0] rpt;
        logic [3:0] ej;
        logic [3:0] ek;
        logic [3:0] eq;   // flop state after the op completes
    } vec_t;

    vec_t tbl[6];

    initial begin
        int         accepted;
        logic [3:0] qx;
        logic       mx;

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_rpt   = '0;

        tbl[0] = '{op: 8'hAA, rpt: 4'd0,  ej: 4'hF, ek: 4'h0, eq: 4'hF};
        tbl[1] = '{op: 8'h03, rpt: 4'd2,  ej: 4'h1, ek: 4'h1, eq: 4'hE};
        tbl[2] = '{op: 8'h55, rpt: 4'd1,  ej: 4'h0, ek: 4'hF, eq: 4'h0};
        tbl[3] = '{op: 8'h03, rpt: 4'd2,  ej: 4'h1, ek: 4'h1, eq: 4'h1};
        tbl[4] = '{op: 8'hC3, rpt: 4'd0,  ej: 4'h9, ek: 4'h9, eq: 4'h8};
        tbl[5] = '{op: 8'h90, rpt: 4'd15, ej: 4'h8, ek: 4'h4, eq: 4'h8};

        do_reset();
        tick();

        for (int r = 0; r < 6; r++) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = tbl[r].op;
            cmd_if.cmd_rpt   = tbl[r].rpt;
            tick();
            cmd_if.cmd_valid = 1'b0;
            for (int c = 0; c <= int'(tbl[r].rpt); c++) begin
                tick();
                check("tbl_j", j, tbl[r].ej);
                check("tbl_k", k, tbl[r].ek);
            end
            tick();
`ifdef JK_SEQ_CHECK_EN
            qx = tbl[r].eq;
`else
            qx = 4'h0;
`endif
            check("tbl_j_end",  j,     4'h0);
            check("tbl_k_end",  k,     4'h0);
            check("tbl_q_exp",  q_exp, qx);
            check("tbl_no_mis", mismatch, 1'b0);
        end

        // Backpressure: long first command, then five more offered one per cycle
        accepted = 0;
        cmd_if.cmd_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cmd_if.cmd_op  = 8'($urandom);
            cmd_if.cmd_rpt = (c == 0) ? 4'd7 : 4'd1;
            if (cmd_if.cmd_ready) accepted++;
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        check("bp_accepted",  accepted,         5);
        check("bp_ready_low", cmd_if.cmd_ready, 1'b0);
        check("bp_busy",      busy,             1'b1);
        drain();

        // Compare: corrupt q_fb[2] for one cycle
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 8'hAA;
        cmd_if.cmd_rpt   = 4'd0;
        tick();
        cmd_if.cmd_valid = 1'b0;
        drain();
        inj = 4'b0100;
        tick();
        inj = 4'b0000;
        for (int t = 0; t < 4; t++) tick();
`ifdef JK_SEQ_CHECK_EN
        mx = 1'b1;
`else
        mx = 1'b0;
`endif
        check("mis_sticky", mismatch, mx);
        do_reset();
        tick();

        // Mid-operation reset with two entries queued
        cmd_if.cmd_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cmd_if.cmd_op  = 8'hF0 | 8'(c);
            cmd_if.cmd_rpt = 4'd5;
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        tick();
        check("mid_busy_pre", busy, 1'b1);
        #2;
        do_reset();
        for (int t = 0; t < 10; t++) tick();
        check("mid_j_after",    j,    4'h0);
        check("mid_busy_after", busy, 1'b0);

        // Randomised traffic against the model
        for (int t = 0; t < 600; t++) begin
            cmd_if.cmd_valid = ($urandom_range(2) != 0);
            cmd_if.cmd_op    = 8'($urandom);
            cmd_if.cmd_rpt   = ($urandom_range(7) == 0) ? 4'd15 : 4'($urandom_range(2));
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
